vec_lane_sequencer: RTL and testbench

- Multi-cycle sequencer for vector instructions in the ARM single-cycle core.
- When the controller flags a condition-passed vector instruction, this block stalls the PC and steps the shared scalar ALU across vector lanes, one lane per cycle.
- For each lane it drives the lane index, the ALU operation and the vector register-file write enable.
- When all lanes are written it releases the stall and pulses a done flag.

---
 rtl/vec_lane_sequencer.sv | 98 +++++++++
 tb/tb_vec_lane_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/vec_lane_sequencer.sv
// Vector lane sequencer: stalls the core and steps the shared scalar ALU
// across vector lanes, one lane per cycle, then pulses VecDone.
module vec_lane_sequencer #(
  parameter int LANES = 4,
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             VecStart,
  input  logic [2:0]       VecOp,
  input  logic [LEN_W-1:0] VecLen,
  output logic             Stall,
  output logic [LEN_W-1:0] LaneIdx,
  output logic [2:0]       LaneALUControl,
  output logic             LaneWrite,
  output logic             VecDone
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(LANES);

  state_t           state;
  logic [LEN_W-1:0] count;
  logic [2:0]       op;
  logic [LEN_W-1:0] len;
  logic             runStall;
  logic [LEN_W-1:0] effLen;

  assign effLen = (VecLen > MAX_LEN) ? MAX_LEN : VecLen;

  // The accept cycle must hold the PC before any register has changed,
  // so that one term of Stall bypasses the registered outputs.
  assign Stall = runStall | ((state == IDLE) && VecStart && !reset);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      op             <= '0;
      len            <= '0;
      runStall       <= 1'b0;
      LaneWrite      <= 1'b0;
      LaneIdx        <= '0;
      LaneALUControl <= '0;
      VecDone        <= 1'b0;
    end else begin
      runStall       <= 1'b0;
      LaneWrite      <= 1'b0;
      LaneIdx        <= '0;
      LaneALUControl <= '0;
      VecDone        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (VecStart) begin
            op    <= VecOp;
            len   <= effLen;
            count <= '0;
            if (effLen == '0) begin
              state   <= DONE;
              VecDone <= 1'b1;
            end else begin
              state          <= RUN;
              runStall       <= 1'b1;
              LaneWrite      <= 1'b1;
              LaneALUControl <= VecOp;
            end
          end
        end
        RUN: begin
          // Outputs are registered, so they are loaded for the lane after count.
          if (count == len - LEN_W'(1)) begin
            state   <= DONE;
            count   <= '0;
            VecDone <= 1'b1;
          end else begin
            count          <= count + LEN_W'(1);
            runStall       <= 1'b1;
            LaneWrite      <= 1'b1;
            LaneIdx        <= count + LEN_W'(1);
            LaneALUControl <= op;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Directed bench for vec_lane_sequencer; outputs are sampled 2ns after
// each rising edge and compared against hand-computed cycle tables.
module tb_vec_lane_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       VecStart;
  logic [2:0] VecOp;
  logic [2:0] VecLen;
  logic       Stall;
  logic [2:0] LaneIdx;
  logic [2:0] LaneALUControl;
  logic       LaneWrite;
  logic       VecDone;

  int compared = 0;
  int mismatched = 0;

  vec_lane_sequencer #(.LANES(4), .LEN_W(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .VecStart       (VecStart),
    .VecOp          (VecOp),
    .VecLen         (VecLen),
    .Stall          (Stall),
    .LaneIdx        (LaneIdx),
    .LaneALUControl (LaneALUControl),
    .LaneWrite      (LaneWrite),
    .VecDone        (VecDone)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic start, input logic [2:0] op, input logic [2:0] len);
    VecStart = start;
    VecOp    = op;
    VecLen   = len;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic stall, input logic write,
                             input logic [2:0] idx, input logic [2:0] alu, input logic done);
    compared += 5;
    assert (Stall === stall) else begin
      mismatched++;
      $error("[TB] FAIL %s Stall: observed %b expected %b", tag, Stall, stall);
    end
    assert (LaneWrite === write) else begin
      mismatched++;
      $error("[TB] FAIL %s LaneWrite: observed %b expected %b", tag, LaneWrite, write);
    end
    assert (LaneIdx === idx) else begin
      mismatched++;
      $error("[TB] FAIL %s LaneIdx: observed %0d expected %0d", tag, LaneIdx, idx);
    end
    assert (LaneALUControl === alu) else begin
      mismatched++;
      $error("[TB] FAIL %s LaneALUControl: observed %b expected %b", tag, LaneALUControl, alu);
    end
    assert (VecDone === done) else begin
      mismatched++;
      $error("[TB] FAIL %s VecDone: observed %b expected %b", tag, VecDone, done);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 3'b000, 3'd0);
    tick();
    tick();
    checkOutput("reset", 1'b0, 1'b0, 3'd0, 3'b000, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("idle%0d", i), 1'b0, 1'b0, 3'd0, 3'b000, 1'b0);
    end

    // Four lanes, op 010
    applyStimulus(1'b1, 3'b010, 3'd4);
    checkOutput("len4_accept", 1'b1, 1'b0, 3'd0, 3'b000, 1'b0);
    tick();
    applyStimulus(1'b0, 3'b000, 3'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("len4_lane%0d", i), 1'b1, 1'b1, 3'(i), 3'b010, 1'b0);
      tick();
    end
    checkOutput("len4_done", 1'b0, 1'b0, 3'd0, 3'b000, 1'b1);
    tick();
    checkOutput("len4_idle", 1'b0, 1'b0, 3'd0, 3'b000, 1'b0);

    // Zero-length instruction goes straight to DONE
    applyStimulus(1'b1, 3'b111, 3'd0);
    checkOutput("len0_accept", 1'b1, 1'b0, 3'd0, 3'b000, 1'b0);
    tick();
    applyStimulus(1'b0, 3'b000, 3'd0);
    checkOutput("len0_done", 1'b0, 1'b0, 3'd0, 3'b000, 1'b1);
    tick();
    checkOutput("len0_idle", 1'b0, 1'b0, 3'd0, 3'b000, 1'b0);

    // Length 7 clamps to 4; inputs changed mid-run must be ignored
    applyStimulus(1'b1, 3'b110, 3'd7);
    checkOutput("clamp_accept", 1'b1, 1'b0, 3'd0, 3'b000, 1'b0);
    tick();
    applyStimulus(1'b0, 3'b001, 3'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("clamp_lane%0d", i), 1'b1, 1'b1, 3'(i), 3'b110, 1'b0);
      tick();
    end
    checkOutput("clamp_done", 1'b0, 1'b0, 3'd0, 3'b000, 1'b1);
    tick();
    checkOutput("clamp_idle", 1'b0, 1'b0, 3'd0, 3'b000, 1'b0);

    // VecStart held through DONE, then back-to-back length-2 instruction
    applyStimulus(1'b1, 3'b011, 3'd1);
    checkOutput("b2b_accept1", 1'b1, 1'b0, 3'd0, 3'b000, 1'b0);
    tick();
    checkOutput("b2b_lane0_first", 1'b1, 1'b1, 3'd0, 3'b011, 1'b0);
    tick();
    applyStimulus(1'b1, 3'b100, 3'd2);
    checkOutput("b2b_done1", 1'b0, 1'b0, 3'd0, 3'b000, 1'b1);
    tick();
    checkOutput("b2b_accept2", 1'b1, 1'b0, 3'd0, 3'b000, 1'b0);
    tick();
    checkOutput("b2b_lane0", 1'b1, 1'b1, 3'd0, 3'b100, 1'b0);
    tick();
    applyStimulus(1'b0, 3'b000, 3'd0);
    checkOutput("b2b_lane1", 1'b1, 1'b1, 3'd1, 3'b100, 1'b0);
    tick();
    checkOutput("b2b_done2", 1'b0, 1'b0, 3'd0, 3'b000, 1'b1);
    tick();
    checkOutput("b2b_idle", 1'b0, 1'b0, 3'd0, 3'b000, 1'b0);

    // Reset while lane 1 is being written aborts the instruction
    applyStimulus(1'b1, 3'b101, 3'd4);
    checkOutput("abort_accept", 1'b1, 1'b0, 3'd0, 3'b000, 1'b0);
    tick();
    applyStimulus(1'b0, 3'b000, 3'd0);
    checkOutput("abort_lane0", 1'b1, 1'b1, 3'd0, 3'b101, 1'b0);
    tick();
    reset = 1'b1;
    checkOutput("abort_lane1", 1'b1, 1'b1, 3'd1, 3'b101, 1'b0);
    tick();
    reset = 1'b0;
    checkOutput("abort_reset", 1'b0, 1'b0, 3'd0, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("abort_quiet%0d", i), 1'b0, 1'b0, 3'd0, 3'b000, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
